// File: rtl/event_enq_arbiter_if.sv
// Bundle between the simulation cores, the enqueue arbiter and the pheap enqueue port.
// The arbiter takes the slave view; whoever drives the cores and heap status takes the master view.
interface event_enq_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
);
  logic [NUM_PORTS-1:0]       in_valid;
  logic [NUM_PORTS*WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]       in_ack;
  logic                       heap_ready;
  logic                       heap_full;
  logic                       deq_active;
  logic                       heap_enq;
  logic [WIDTH-1:0]           heap_data;
  logic [NUM_PORTS-1:0]       pending;
  logic [31:0]                enq_count;

  modport master (
    output in_valid, in_data, heap_ready, heap_full, deq_active,
    input  in_ack, heap_enq, heap_data, pending, enq_count
  );

  modport slave (
    input  in_valid, in_data, heap_ready, heap_full, deq_active,
    output in_ack, heap_enq, heap_data, pending, enq_count
  );
endinterface

// File: rtl/event_enq_arbiter.sv
// Round-robin serialiser of per-core events into the single pheap enqueue port.
// Each core owns a one-entry buffer; at most one enqueue is issued every other cycle.
module event_enq_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 32
) (
  input logic               clk,
  input logic               rst,
  event_enq_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [0:0] {
    ARB = 1'b0,
    GAP = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] pending_q;
  logic [WIDTH-1:0]     event_buf [NUM_PORTS];
  logic                 heap_enq_q;
  logic [WIDTH-1:0]     heap_data_q;
  logic [31:0]          enq_count_q;

  logic [NUM_PORTS-1:0] in_ack;
  logic                 eligible;
  logic                 grant;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;

  // Ack depends only on registered occupancy, so a freed slot cannot be refilled in the same cycle.
  assign in_ack = bus.in_valid & ~pending_q;

  assign bus.in_ack    = in_ack;
  assign bus.heap_enq  = heap_enq_q;
  assign bus.heap_data = heap_data_q;
  assign bus.pending   = pending_q;
  assign bus.enq_count = enq_count_q;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!grant_found && pending_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    eligible   = 1'b0;
    grant      = 1'b0;
    case (state)
      ARB: begin
        eligible = (|pending_q) && bus.heap_ready && !bus.heap_full && !bus.deq_active;
        grant    = eligible && grant_found;
        if (grant) begin
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = ARB;
      end
      default: begin
        state_next = ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      heap_enq_q  <= 1'b0;
      heap_data_q <= '0;
      enq_count_q <= '0;
      rr_ptr      <= LAST_PORT;
    end else begin
      heap_enq_q <= grant;
      if (grant) begin
        heap_data_q <= event_buf[grant_idx];
        rr_ptr      <= grant_idx;
        enq_count_q <= enq_count_q + 32'd1;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant && (grant_idx == PTR_W'(i))) begin
          pending_q[i] <= 1'b0;
        end else if (in_ack[i]) begin
          pending_q[i] <= 1'b1;
        end
      end
    end
  end

  // Buffer contents are meaningless while the matching pending bit is clear, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_ack[i]) begin
        event_buf[i] <= bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_event_enq_arbiter.sv
// Directed bench for event_enq_arbiter: hand-computed cycle-by-cycle expectations.
module tb_event_enq_arbiter;

  localparam int NP = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  event_enq_arbiter_if #(.NUM_PORTS(NP), .WIDTH(W)) bus ();

  event_enq_arbiter #(.NUM_PORTS(NP), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [NP*W-1:0] pack4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                            input logic [W-1:0] d2, input logic [W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NP-1:0] valid, input logic [NP*W-1:0] data,
                               input logic ready, input logic full, input logic deq);
    bus.in_valid   = valid;
    bus.in_data    = data;
    bus.heap_ready = ready;
    bus.heap_full  = full;
    bus.deq_active = deq;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  logic        expEnq [10];
  logic [31:0] expDat [10];

  initial begin
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);

    // Single event from port 0: ack in cycle 0, enqueue visible in cycle 2.
    doReset();
    applyStimulus(4'b0001, pack4(32'd9, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rst_pending", bus.pending, 4'b0000);
    checkOutput("rst_heap_enq", bus.heap_enq, 1'b0);
    checkOutput("rst_heap_data", bus.heap_data, 32'd0);
    checkOutput("rst_enq_count", bus.enq_count, 32'd0);
    checkOutput("t1_ack_c0", bus.in_ack, 4'b0001);
    nextCycle();
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t1_pending_c1", bus.pending, 4'b0001);
    checkOutput("t1_enq_c1", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_enq_c2", bus.heap_enq, 1'b1);
    checkOutput("t1_data_c2", bus.heap_data, 32'd9);
    checkOutput("t1_count_c2", bus.enq_count, 32'd1);
    checkOutput("t1_pending_c2", bus.pending, 4'b0000);
    nextCycle();
    @(negedge clk);
    checkOutput("t1_enq_c3", bus.heap_enq, 1'b0);

    // All four ports at once: enqueues in cycles 2,4,6,8 in port order.
    doReset();
    applyStimulus(4'b1111, pack4(32'd3, 32'd8, 32'd4, 32'd15), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t2_ack_c0", bus.in_ack, 4'b1111);
    expEnq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    expDat = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd8, 32'd0, 32'd4, 32'd0, 32'd15, 32'd0};
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("t2_enq_c%0d", c), bus.heap_enq, expEnq[c]);
      if (expEnq[c]) checkOutput($sformatf("t2_data_c%0d", c), bus.heap_data, expDat[c]);
    end
    checkOutput("t2_count", bus.enq_count, 32'd4);

    // rr_ptr left at 2 with port 2 refilled; port 0 joins and must win first.
    doReset();
    applyStimulus(4'b0100, pack4(0, 0, 32'h22, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_ack_c0", bus.in_ack, 4'b0100);
    nextCycle();
    applyStimulus(4'b0000, pack4(0, 0, 32'h22, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_pending_c1", bus.pending, 4'b0100);
    nextCycle();
    applyStimulus(4'b0100, pack4(0, 0, 32'h55, 0), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3_enq_c2", bus.heap_enq, 1'b1);
    checkOutput("t3_data_c2", bus.heap_data, 32'h22);
    checkOutput("t3_ack_c2", bus.in_ack, 4'b0100);
    nextCycle();
    applyStimulus(4'b0001, pack4(32'h11, 0, 32'h55, 0), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3_enq_c3", bus.heap_enq, 1'b0);
    checkOutput("t3_ack_c3", bus.in_ack, 4'b0001);
    nextCycle();
    applyStimulus(4'b0000, pack4(32'h11, 0, 32'h55, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_pending_c4", bus.pending, 4'b0101);
    checkOutput("t3_enq_c4", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_enq_c5", bus.heap_enq, 1'b1);
    checkOutput("t3_data_c5", bus.heap_data, 32'h11);
    checkOutput("t3_pending_c5", bus.pending, 4'b0100);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_enq_c6", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t3_enq_c7", bus.heap_enq, 1'b1);
    checkOutput("t3_data_c7", bus.heap_data, 32'h55);
    checkOutput("t3_pending_c7", bus.pending, 4'b0000);

    // Heap full with ports 1 and 3 buffered: everything holds until full drops.
    doReset();
    applyStimulus(4'b1010, pack4(0, 32'hA1, 0, 32'hA3), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t4_ack_c0", bus.in_ack, 4'b1010);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      applyStimulus((c == 3) ? 4'b0010 : 4'b0000,
                    pack4(0, (c == 3) ? 32'hF1 : 32'hA1, 0, 32'hA3), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("t4_enq_c%0d", c), bus.heap_enq, 1'b0);
      checkOutput($sformatf("t4_pending_c%0d", c), bus.pending, 4'b1010);
      if (c == 3) checkOutput("t4_reoffer_ack", bus.in_ack, 4'b0000);
    end
    nextCycle();
    applyStimulus(4'b0000, pack4(0, 32'hA1, 0, 32'hA3), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t4_enq_c5", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_enq_c6", bus.heap_enq, 1'b1);
    checkOutput("t4_data_c6", bus.heap_data, 32'hA1);
    checkOutput("t4_pending_c6", bus.pending, 4'b1000);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_enq_c7", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t4_enq_c8", bus.heap_enq, 1'b1);
    checkOutput("t4_data_c8", bus.heap_data, 32'hA3);

    // One-cycle deq_active defers the first grant by exactly one cycle.
    doReset();
    applyStimulus(4'b0011, pack4(32'h30, 32'h31, 0, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_ack_c0", bus.in_ack, 4'b0011);
    nextCycle();
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_pending_c1", bus.pending, 4'b0011);
    checkOutput("t5_enq_c1", bus.heap_enq, 1'b0);
    nextCycle();
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t5_enq_c2", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_enq_c3", bus.heap_enq, 1'b1);
    checkOutput("t5_data_c3", bus.heap_data, 32'h30);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_enq_c4", bus.heap_enq, 1'b0);
    nextCycle();
    @(negedge clk);
    checkOutput("t5_enq_c5", bus.heap_enq, 1'b1);
    checkOutput("t5_data_c5", bus.heap_data, 32'h31);
    checkOutput("t5_count_c5", bus.enq_count, 32'd2);

    // Reset right after port 0 is acked discards the buffered event.
    nextCycle();
    applyStimulus(4'b0001, pack4(32'h77, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_ack_c6", bus.in_ack, 4'b0001);
    nextCycle();
    rst = 1'b1;
    applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t6_pending_c7", bus.pending, 4'b0001);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_pending_c8", bus.pending, 4'b0000);
    checkOutput("t6_enq_c8", bus.heap_enq, 1'b0);
    checkOutput("t6_count_c8", bus.enq_count, 32'd0);
    checkOutput("t6_data_c8", bus.heap_data, 32'd0);
    for (int c = 9; c <= 10; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput($sformatf("t6_enq_c%0d", c), bus.heap_enq, 1'b0);
      checkOutput($sformatf("t6_count_c%0d", c), bus.enq_count, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/event_enq_arbiter.md
# event_enq_arbiter

Collects newly generated events from NUM_PORTS simulation cores and serialises them into the single enqueue port of the pipelined event heap (pheap). Each core gets a one-entry holding buffer and a valid/ack handshake. A round-robin arbiter issues at most one heap enqueue every other cycle, and only when the heap reports ready, not full, and no dequeue in the same cycle. The block sits directly upstream of the heap's enq/inp_data inputs.

## Interface
- NUM_PORTS, 4, number of core submission ports (2..16)
- WIDTH, 32, event word width; matches heap WIDTH
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_PORTS  per-port event offered; held until acked
- in_data  input  NUM_PORTS*WIDTH  per-port event; port i at bits [i*WIDTH +: WIDTH]
- in_ack  output  NUM_PORTS  combinational; in_ack[i] = in_valid[i] & ~pending[i]
- heap_ready  input  1  heap ready, from pheap
- heap_full  input  1  heap full, from pheap
- deq_active  input  1  downstream dequeuer asserting heap deq this cycle
- heap_enq  output  1  registered one-cycle enqueue pulse to heap
- heap_data  output  WIDTH  registered event word; valid while heap_enq=1
- pending  output  NUM_PORTS  registered per-port buffer occupancy
- enq_count  output  32  registered count of issued enqueues; wraps at 2^32

## Operation
- Capture: in_ack[i]=1 in a cycle → buf[i]<=in_data[i], pending[i]<=1 at that edge. A core must not change in_data while in_valid=1 and ack=0.
- Arbitration eligibility: in cycle t the arbiter grants iff all of the following hold:
  - state=ARB
  - |pending
  - heap_ready=1
  - heap_full=0
  - deq_active=0
- Grant selection: the first set pending bit strictly after rr_ptr, scanning cyclically upward.
- On grant to port g at edge t:
  - heap_enq<=1, heap_data<=buf[g]
  - pending[g]<=0, rr_ptr<=g
  - enq_count<=enq_count+1
  - state<=GAP
- States:
  - ARB: grant possible. Stays in ARB while no grant.
  - GAP: heap_enq high. Unconditionally returns to ARB next edge; no grant evaluated in GAP.
- heap_enq is never high on two consecutive cycles, so the heap's registered ready has time to fall.
- Draining and refilling the same port: a port freed at edge t acks again no earlier than cycle t+1, because pending[g] is still 1 during cycle t. No same-cycle bypass.
- heap_full or deq_active high → hold all buffers indefinitely, no drops; cores backpressure via in_ack=0.
- Reset (rst=1 at edge):
  - pending=0, heap_enq=0, heap_data=0, enq_count=0
  - state=ARB, rr_ptr=NUM_PORTS-1, so port 0 wins first
  - buffer contents are don't-care
  - in_ack evaluates from pending=0 in the cycle after reset.
- Reset mid-operation discards buffered events; events already enqueued are unaffected.

## Timing
- Core ack in cycle t → pending high in t+1 → earliest grant evaluated in t+1 → heap_enq high in t+2. Minimum latency 2 cycles.
- Peak throughput: 1 enqueue per 2 cycles, regardless of NUM_PORTS.
- Fairness: a continuously pending port is granted within NUM_PORTS grants.
- in_ack is purely combinational from in_valid and registered pending; no combinational path from heap_ready to in_ack.
- Eligibility inputs (heap_ready, heap_full, deq_active) are sampled in the grant cycle only.

## Test plan
- Reset, then port 0 offers 9 at cycle 0 with heap_ready=1:
  - in_ack[0]=1 in cycle 0
  - heap_enq=1, heap_data=9 in cycle 2
  - enq_count=1, pending=0 afterwards
- All 4 ports offer distinct values (3,8,4,15) in the same cycle after reset:
  - heap_enq in cycles 2,4,6,8 with data 3,8,4,15 (port order 0,1,2,3)
  - never two consecutive heap_enq cycles
- Port 2 pending, rr_ptr=2, then ports 0 and 2 both pending: grant goes to port 0 first, then port 2 two cycles later.
- heap_full=1 while ports 1 and 3 pending:
  - no heap_enq, pending stays 4'b1010
  - in_ack[1]=0 on re-offer
  - heap_full falls at cycle k → heap_enq at k+1 carries port 1 data.
- deq_active=1 for one cycle in which a grant would occur: the grant is deferred exactly one cycle; data and order are unchanged.
- rst asserted the cycle after port 0 is acked:
  - pending=0, heap_enq stays 0, enq_count=0
  - the buffered event is never enqueued.
